tlul_arbiter_2to1: RTL

- Two-master to one-slave TileLink-UL arbiter that shares a single peripheral slave (GPIO, timer, UART) between two requesters, e.g. a core data port and a debug module.
- Arbitrates the A channel round-robin, tags the slave-side source with the winning master index, and routes D responses back by that tag.
- Per-master outstanding-request counters throttle each master to MAX_OUT in-flight transactions.
- Zero-cycle pass-through datapath; only grant, lock and counter state is registered.

---
 rtl/tlul_arbiter_2to1.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tlul_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tlul_arbiter_2to1
//
// Shares one TileLink-UL peripheral slave between two masters. The A channel
// is arbitrated round-robin, and the slave-side source is tagged with the
// winning master index. D responses are routed back by that tag. A per-master
// outstanding counter stops each master at MAX_OUT in-flight requests. The
// datapath is a zero-cycle pass-through. Only the grant, lock and counter state
// is registered.
//
// Build option:
//   TLARB_FIXED_PRIO_EN - When this macro is defined, master 0 always wins a
//                         tie and the last-granted register is not built.
//                         Lock and counters behave as in round-robin mode.
//
// Ports:
//   tlarb_clock_i      clock
//   tlarb_reset_i      asynchronous active-low reset; while it is low, every
//                      valid and ready output is forced to 0
//   tlarb_m_a_*        A channel from the masters (bit/slice i = master i)
//   tlarb_m_d_*        D channel to the masters (source and payload broadcast)
//   tlarb_s_a_*        A channel to the slave, source = {grant index, source}
//   tlarb_s_d_*        D channel from the slave, source MSB selects the master
// -----------------------------------------------------------------------------
module tlul_arbiter_2to1 #(
    parameter int TL_RS   = 4,
    parameter int AW      = 2,
    parameter int MAX_OUT = 2,
    parameter int PW      = 47 + AW
) (
    input  logic                  tlarb_clock_i,
    input  logic                  tlarb_reset_i,
    input  logic [1:0]            tlarb_m_a_valid,
    output logic [1:0]            tlarb_m_a_ready,
    input  logic [2*TL_RS-1:0]    tlarb_m_a_source,
    input  logic [2*PW-1:0]       tlarb_m_a_pay,
    output logic [1:0]            tlarb_m_d_valid,
    input  logic [1:0]            tlarb_m_d_ready,
    output logic [TL_RS-1:0]      tlarb_m_d_source,
    output logic [42:0]           tlarb_m_d_pay,
    output logic                  tlarb_s_a_valid,
    input  logic                  tlarb_s_a_ready,
    output logic [TL_RS:0]        tlarb_s_a_source,
    output logic [PW-1:0]         tlarb_s_a_pay,
    input  logic                  tlarb_s_d_valid,
    output logic                  tlarb_s_d_ready,
    input  logic [TL_RS:0]        tlarb_s_d_source,
    input  logic [42:0]           tlarb_s_d_pay
);

    localparam int              CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUT);
    localparam logic [CW-1:0]   CNT_ONE = CW'(32'd1);

    // Counter step: +1 on A fire, -1 on D fire, and no change when both occur.
    // A decrement from zero is a protocol violation. It saturates at zero
    // instead of wrapping.
    function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                               input logic          inc,
                                               input logic          dec);
        logic [CW-1:0] res;
        res = cnt;
        case ({inc, dec})
            2'b10:   res = cnt + CNT_ONE;
            2'b01:   res = (cnt == {CW{1'b0}}) ? cnt : (cnt - CNT_ONE);
            default: res = cnt;
        endcase
        return res;
    endfunction

    logic          gnt_r;
    logic          lock_r;
    logic [CW-1:0] cnt0_r;
    logic [CW-1:0] cnt1_r;
`ifndef TLARB_FIXED_PRIO_EN
    logic          last_r;
    logic          last_nxt_s;
`endif

    logic [1:0]    can_s;
    logic [1:0]    elig_s;
    logic          sel_s;
    logic          g_s;
    logic          a_valid_s;
    logic          a_fire_s;
    logic          d_tag_s;
    logic          d_ready_s;
    logic          d_fire_s;
    logic          gnt_nxt_s;
    logic          lock_nxt_s;
    logic [CW-1:0] cnt0_nxt_s;
    logic [CW-1:0] cnt1_nxt_s;

    // Eligibility: the master is requesting and still has credit.
    always_comb begin
        can_s    = {(cnt1_r < MAX_C), (cnt0_r < MAX_C)};
        elig_s   = tlarb_m_a_valid & can_s;
        d_tag_s  = tlarb_s_d_source[TL_RS];
        d_ready_s = tlarb_m_d_ready[d_tag_s];
    end

    // Unlocked selection. When neither master is eligible, keep the old grant
    // so that the A outputs do not toggle needlessly.
    always_comb begin
        sel_s = gnt_r;
        case (elig_s)
            2'b01:   sel_s = 1'b0;
            2'b10:   sel_s = 1'b1;
`ifdef TLARB_FIXED_PRIO_EN
            2'b11:   sel_s = 1'b0;
`else
            2'b11:   sel_s = ~last_r;
`endif
            default: sel_s = gnt_r;
        endcase
    end

    // A channel mux. The locked grant keeps a stalled request stable on the slave.
    always_comb begin
        g_s              = lock_r ? gnt_r : sel_s;
        a_valid_s        = elig_s[g_s];
        a_fire_s         = a_valid_s & tlarb_s_a_ready;
        tlarb_s_a_pay    = g_s ? tlarb_m_a_pay[PW +: PW] : tlarb_m_a_pay[0 +: PW];
        tlarb_s_a_source = {g_s, (g_s ? tlarb_m_a_source[TL_RS +: TL_RS]
                                      : tlarb_m_a_source[0 +: TL_RS])};
        tlarb_m_a_ready  = 2'b00;
        tlarb_s_a_valid  = 1'b0;
        if (tlarb_reset_i) begin
            tlarb_s_a_valid      = a_valid_s;
            tlarb_m_a_ready[g_s] = tlarb_s_a_ready & can_s[g_s];
        end else begin
            tlarb_s_a_valid      = 1'b0;
            tlarb_m_a_ready      = 2'b00;
        end
    end

    // D channel demux. The source MSB is the tag added on the A channel.
    always_comb begin
        tlarb_m_d_source = tlarb_s_d_source[TL_RS-1:0];
        tlarb_m_d_pay    = tlarb_s_d_pay;
        d_fire_s         = tlarb_s_d_valid & d_ready_s;
        if (tlarb_reset_i) begin
            tlarb_m_d_valid = {tlarb_s_d_valid & d_tag_s, tlarb_s_d_valid & ~d_tag_s};
            tlarb_s_d_ready = d_ready_s;
        end else begin
            tlarb_m_d_valid = 2'b00;
            tlarb_s_d_ready = 1'b0;
        end
    end

    // Next state for lock, grant, last-granted and the counters.
    always_comb begin
        gnt_nxt_s  = gnt_r;
        lock_nxt_s = lock_r;
`ifndef TLARB_FIXED_PRIO_EN
        last_nxt_s = last_r;
`endif
        if (a_valid_s && !tlarb_s_a_ready) begin
            lock_nxt_s = 1'b1;
            gnt_nxt_s  = g_s;
        end else if (a_fire_s) begin
            lock_nxt_s = 1'b0;
`ifndef TLARB_FIXED_PRIO_EN
            last_nxt_s = g_s;
`endif
        end else begin
            lock_nxt_s = lock_r;
            gnt_nxt_s  = gnt_r;
        end
        cnt0_nxt_s = cnt_step(cnt0_r, a_fire_s & ~g_s, d_fire_s & ~d_tag_s);
        cnt1_nxt_s = cnt_step(cnt1_r, a_fire_s &  g_s, d_fire_s &  d_tag_s);
    end

    // State registers. After reset, last = 1 so that master 0 wins the first tie.
    always_ff @(posedge tlarb_clock_i or negedge tlarb_reset_i) begin
        if (!tlarb_reset_i) begin
            gnt_r  <= 1'b0;
            lock_r <= 1'b0;
            cnt0_r <= {CW{1'b0}};
            cnt1_r <= {CW{1'b0}};
`ifndef TLARB_FIXED_PRIO_EN
            last_r <= 1'b1;
`endif
        end else begin
            gnt_r  <= gnt_nxt_s;
            lock_r <= lock_nxt_s;
            cnt0_r <= cnt0_nxt_s;
            cnt1_r <= cnt1_nxt_s;
`ifndef TLARB_FIXED_PRIO_EN
            last_r <= last_nxt_s;
`endif
        end
    end

endmodule
